enduro_sync_axis_fifo: RTL and testbench
========================================

ENDURO_SYNC_AXIS_FIFO -- requirements
Module: enduro_sync_axis_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: tdata width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: address bits; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter FULL_THRESH, default 60: almost_full asserts when fill_level >= FULL_THRESH.
REQ-004 SHALL have parameter EMPTY_THRESH, default 2: almost_empty asserts when fill_level <= EMPTY_THRESH.
REQ-005 SHALL have parameter PACKET_MODE, default 0: 1 = store-and-forward on tlast, 0 = cut-through.
REQ-006 SHALL have port axis_clk, input, 1: single clock; all logic is rising-edge.
REQ-007 SHALL have port axis_aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port group s_axis_tdata/tlast/tvalid, input, DATA_WIDTH/1/1, plus s_axis_tready, output, 1: AXI4-Stream slave.
REQ-009 SHALL have port group m_axis_tdata/tlast/tvalid, output, DATA_WIDTH/1/1, plus m_axis_tready, input, 1: AXI4-Stream master.
REQ-010 SHALL have port fill_level, output, ADDR_WIDTH+1: stored beats, range 0..DEPTH.
REQ-011 SHALL have ports almost_full and almost_empty, output, 1 each: threshold flags.
REQ-012 SHALL have port pkt_count, output, ADDR_WIDTH+1: complete packets (tlast stored) held.

Function
REQ-013 SHALL write a beat {tdata,tlast} on a rising edge where s_axis_tvalid && s_axis_tready.
REQ-014 SHALL drive s_axis_tready = !full, with full = (fill_level == DEPTH); no write-through when full, even if a read occurs in the same cycle.
REQ-015 SHALL present the head entry combinationally on m_axis_tdata/tlast; a beat written at edge k is visible with m_axis_tvalid high from edge k onward (one-cycle latency, empty to valid).
REQ-016 SHALL, with PACKET_MODE=0, drive m_axis_tvalid = (fill_level != 0).
REQ-017 SHALL, with PACKET_MODE=1, drive m_axis_tvalid = (fill_level != 0) && (pkt_count != 0 || full); the full term releases oversize packets and prevents deadlock.
REQ-018 SHALL pop the head on an edge where m_axis_tvalid && m_axis_tready.
REQ-019 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid && !m_axis_tready (AXI stability).
REQ-020 SHALL update fill_level by +1 on write only, -1 on read only, and 0 when both occur in the same cycle.
REQ-021 SHALL update pkt_count by +1 on a write with tlast, -1 on a read with tlast, and 0 when both occur in the same cycle.
REQ-022 SHALL wrap the ADDR_WIDTH-bit write and read pointers modulo DEPTH with no gap entry; all DEPTH entries are usable.
REQ-023 SHALL register almost_full and almost_empty from the next-state fill_level, so they are exact in the same cycle as fill_level.
REQ-024 SHALL treat FULL_THRESH > DEPTH or EMPTY_THRESH >= FULL_THRESH as illegal and flag it with an elaboration-time assertion.

Reset
REQ-025 SHALL, while axis_aresetn is low, clear both pointers, fill_level and pkt_count to 0, and drive s_axis_tready=0, m_axis_tvalid=0, almost_full=0 and almost_empty=1.
REQ-026 SHALL drive s_axis_tready=1 on the first edge after reset release; reset in mid-packet discards all contents, including partial packets.
REQ-027 SHALL leave memory contents unreset; only control state is cleared.

Structure
REQ-028 SHALL take any shared beat typedef {tdata,tlast} and the DEPTH/threshold-check constants from package enduro_fifo_pkg.
REQ-029 SHALL instantiate enduro_dual_port_ram (width DATA_WIDTH+1, asynchronous read) as its single sub-module; all pointer and count logic stays in this module.

Verification (ADDR_WIDTH=4, DEPTH=16, FULL_THRESH=14, EMPTY_THRESH=2)
REQ-030 SHALL cover fill to full: 16 writes with m_axis_tready=0 -> fill_level=16, s_axis_tready=0, almost_full high from the 14th write, and the 17th beat is not accepted.
REQ-031 SHALL cover simultaneous access: at fill_level=8, write and read in one cycle -> fill_level stays 8, and 40 beats of streaming preserve order across pointer wrap.
REQ-032 SHALL cover packet mode: PACKET_MODE=1 with a 5-beat packet written -> m_axis_tvalid stays 0 until the tlast beat is written, then is high the next cycle with pkt_count=1.
REQ-033 SHALL cover oversize packet: PACKET_MODE=1 with a 20-beat packet -> at fill_level=16 m_axis_tvalid rises, and all 20 beats drain in order with no deadlock.
REQ-034 SHALL cover mid-stream reset: axis_aresetn pulsed low at fill_level=7 -> fill_level=0, m_axis_tvalid=0 and almost_empty=1 immediately, with no stale beat after release.
REQ-035 SHALL cover backpressure: random m_axis_tready -> m_axis_tdata is unchanged while stalled, and the scoreboard shows zero loss or duplication.

Source files
------------

// File: rtl/enduro_fifo_pkg.sv
// Shared constants and helpers for the enduro synchronous AXI4-Stream FIFO.
// Holds the depth/threshold legality checks and the per-cycle access encoding.
package enduro_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // FULL_THRESH may equal DEPTH; EMPTY_THRESH must sit strictly below it.
  function automatic bit thresholds_legal(input int unsigned addr_width,
                                          input int unsigned full_thresh,
                                          input int unsigned empty_thresh);
    return (full_thresh <= fifo_depth(addr_width)) && (empty_thresh < full_thresh);
  endfunction

endpackage

// File: rtl/enduro_sync_axis_fifo_if.sv
// AXI4-Stream beat channel; master drives data/valid, slave drives ready.
interface enduro_sync_axis_fifo_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/enduro_dual_port_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset on storage.
module enduro_dual_port_ram #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/enduro_sync_axis_fifo.sv
// Single-clock AXI4-Stream FIFO with fill/packet counters, threshold flags
// and an optional store-and-forward mode keyed on tlast.
module enduro_sync_axis_fifo
  import enduro_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int FULL_THRESH  = 60,
  parameter int EMPTY_THRESH = 2,
  parameter int PACKET_MODE  = 0
) (
  input  logic                  axis_clk,
  input  logic                  axis_aresetn,
  enduro_sync_axis_fifo_if.slave  s_axis,
  enduro_sync_axis_fifo_if.master m_axis,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int DEPTH = int'(fifo_depth(ADDR_WIDTH));
  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_LVL  = LVL_W'(FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] EMPTY_LVL = LVL_W'(EMPTY_THRESH);
  localparam bit STORE_FWD = (PACKET_MODE != 0);

  if (!thresholds_legal(ADDR_WIDTH, FULL_THRESH, EMPTY_THRESH)) begin : g_bad_thresholds
    $error("enduro_sync_axis_fifo: need FULL_THRESH <= DEPTH and EMPTY_THRESH < FULL_THRESH");
  end

  typedef struct packed {
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
  } beat_t;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic [ADDR_WIDTH:0]   pkt_q, pkt_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  rdy_en_q, rdy_en_d;

  beat_t    wr_beat;
  beat_t    rd_beat;
  logic     full;
  logic     empty;
  logic     head_valid;
  logic     wr_en;
  logic     rd_en;
  logic     pkt_in;
  logic     pkt_out;
  fifo_op_e op;

  assign full  = (fill_q == DEPTH_LVL);
  assign empty = (fill_q == '0);

  // In store-and-forward mode a full FIFO with no complete packet must still
  // drain, otherwise a packet longer than DEPTH would deadlock the stream.
  assign head_valid = !empty && (!STORE_FWD || (pkt_q != '0) || full);

  assign wr_en   = s_axis.tvalid && rdy_en_q && !full;
  assign rd_en   = head_valid && m_axis.tready;
  assign pkt_in  = wr_en && s_axis.tlast;
  assign pkt_out = rd_en && rd_beat.tlast;
  assign op      = fifo_op_e'({wr_en, rd_en});

  assign wr_beat.tlast = s_axis.tlast;
  assign wr_beat.tdata = s_axis.tdata;

  enduro_dual_port_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (axis_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_beat),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_beat)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    pkt_d    = pkt_q;
    rdy_en_d = 1'b1;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case (op)
      OP_WRITE: fill_d = fill_q + 1'b1;
      OP_READ:  fill_d = fill_q - 1'b1;
      default:  fill_d = fill_q;
    endcase

    case ({pkt_in, pkt_out})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase

    // Flags follow the next-state level so they never lag fill_level.
    afull_d  = (fill_d >= FULL_LVL);
    aempty_d = (fill_d <= EMPTY_LVL);
  end

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      pkt_q    <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      pkt_q    <= pkt_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  assign s_axis.tready = rdy_en_q && !full;
  assign m_axis.tvalid = head_valid;
  assign m_axis.tdata  = rd_beat.tdata;
  assign m_axis.tlast  = rd_beat.tlast;
  assign fill_level    = fill_q;
  assign pkt_count     = pkt_q;
  assign almost_full   = afull_q;
  assign almost_empty  = aempty_q;

endmodule

// File: tb/tb_enduro_sync_axis_fifo.sv
// Bench for enduro_sync_axis_fifo: one cut-through and one packet-mode instance
// compared cycle by cycle against a queue-based reference model.
module tb_enduro_sync_axis_fifo;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int FT    = 14;
  localparam int ET    = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  enduro_sync_axis_fifo_if #(.DATA_WIDTH(DW)) s_if0 ();
  enduro_sync_axis_fifo_if #(.DATA_WIDTH(DW)) m_if0 ();
  enduro_sync_axis_fifo_if #(.DATA_WIDTH(DW)) s_if1 ();
  enduro_sync_axis_fifo_if #(.DATA_WIDTH(DW)) m_if1 ();

  logic [AW:0] fill0, fill1, pkt0, pkt1;
  logic        af0, af1, ae0, ae1;

  enduro_sync_axis_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FULL_THRESH(FT), .EMPTY_THRESH(ET), .PACKET_MODE(0)
  ) u_dut0 (
    .axis_clk(clk), .axis_aresetn(rstn), .s_axis(s_if0), .m_axis(m_if0),
    .fill_level(fill0), .almost_full(af0), .almost_empty(ae0), .pkt_count(pkt0)
  );

  enduro_sync_axis_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FULL_THRESH(FT), .EMPTY_THRESH(ET), .PACKET_MODE(1)
  ) u_dut1 (
    .axis_clk(clk), .axis_aresetn(rstn), .s_axis(s_if1), .m_axis(m_if1),
    .fill_level(fill1), .almost_full(af1), .almost_empty(ae1), .pkt_count(pkt1)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [DW:0] model_q[$];
  bit          rdy_en;
  bit          stalled;
  logic [DW:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pkts();
    int n;
    n = 0;
    foreach (model_q[i]) if (model_q[i][DW]) n++;
    return n;
  endfunction

  // Expected behaviour comes from the queue: size, tlast count and head beat.
  task automatic checkOutput(input int m, output bit exp_valid, output bit exp_ready);
    int            sz;
    int            pk;
    bit            full;
    string         pfx;
    logic [DW-1:0] o_data;
    logic          o_last, o_valid, o_ready, o_af, o_ae;
    logic [AW:0]   o_fill, o_pkt;
    sz   = model_q.size();
    pk   = model_pkts();
    full = (sz == DEPTH);
    if (m == 0) begin
      pfx = "ct_"; o_data = m_if0.tdata; o_last = m_if0.tlast; o_valid = m_if0.tvalid;
      o_ready = s_if0.tready; o_fill = fill0; o_pkt = pkt0; o_af = af0; o_ae = ae0;
    end else begin
      pfx = "pk_"; o_data = m_if1.tdata; o_last = m_if1.tlast; o_valid = m_if1.tvalid;
      o_ready = s_if1.tready; o_fill = fill1; o_pkt = pkt1; o_af = af1; o_ae = ae1;
    end
    exp_valid = (sz != 0) && ((m == 0) || (pk != 0) || full);
    exp_ready = rdy_en && !full;
    chk({pfx, "s_tready"},     32'(o_ready), 32'(exp_ready));
    chk({pfx, "m_tvalid"},     32'(o_valid), 32'(exp_valid));
    chk({pfx, "fill_level"},   32'(o_fill),  32'(sz));
    chk({pfx, "pkt_count"},    32'(o_pkt),   32'(pk));
    chk({pfx, "almost_full"},  32'(o_af),    32'(sz >= FT));
    chk({pfx, "almost_empty"}, 32'(o_ae),    32'(sz <= ET));
    if (exp_valid) begin
      chk({pfx, "head_beat"}, 32'({o_last, o_data}), 32'(model_q[0]));
      if (stalled) chk({pfx, "hold_while_stalled"}, 32'({o_last, o_data}), 32'(held));
    end
  endtask

  task automatic applyStimulus(input int m, input bit sv, input logic [DW-1:0] d,
                               input bit l, input bit mr, output bit acc);
    bit ev, er, wr, rd;
    s_if0.tvalid = (m == 0) && sv; s_if0.tdata = d; s_if0.tlast = l; m_if0.tready = (m == 0) && mr;
    s_if1.tvalid = (m == 1) && sv; s_if1.tdata = d; s_if1.tlast = l; m_if1.tready = (m == 1) && mr;
    #1;
    checkOutput(m, ev, er);
    wr = sv && er;
    rd = ev && mr;
    stalled = ev && !mr;
    if (ev) held = model_q[0];
    @(posedge clk);
    if (rd) void'(model_q.pop_front());
    if (wr) model_q.push_back({l, d});
    rdy_en = 1'b1;
    acc = wr;
    @(negedge clk);
  endtask

  task automatic drainAll(input int m);
    bit acc;
    for (int i = 0; i < 80 && model_q.size() != 0; i++) applyStimulus(m, 1'b0, '0, 1'b0, 1'b1, acc);
    chk((m == 0) ? "ct_drained" : "pk_drained", 32'((m == 0) ? fill0 : fill1), 32'd0);
    stalled = 1'b0;
  endtask

  // Reset lands mid-cycle so the asynchronous clear is observed before any edge.
  task automatic pulseReset();
    bit ev, er;
    #2;
    rstn = 1'b0;
    #1;
    model_q.delete();
    rdy_en  = 1'b0;
    stalled = 1'b0;
    checkOutput(0, ev, er);
    checkOutput(1, ev, er);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ev, er, acc;
    int n;
    s_if0.tvalid = 1'b0; s_if0.tdata = '0; s_if0.tlast = 1'b0; m_if0.tready = 1'b0;
    s_if1.tvalid = 1'b0; s_if1.tdata = '0; s_if1.tlast = 1'b0; m_if1.tready = 1'b0;
    rdy_en = 1'b0; stalled = 1'b0; held = '0;

    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    checkOutput(0, ev, er);
    checkOutput(1, ev, er);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, acc);

    $display("[TB] fill to full with sink stalled");
    for (int i = 0; i < 17; i++) applyStimulus(0, 1'b1, 16'($urandom), 1'($urandom), 1'b0, acc);
    chk("ct_full_level", 32'(fill0), 32'd16);
    chk("ct_full_tready", 32'(s_if0.tready), 32'd0);

    $display("[TB] simultaneous access and streaming across wrap");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, '0, 1'b0, 1'b1, acc);
    applyStimulus(0, 1'b1, 16'h5A5A, 1'b0, 1'b1, acc);
    chk("ct_simul_fill", 32'(fill0), 32'd8);
    for (int i = 0; i < 40; i++) applyStimulus(0, 1'b1, 16'(16'h1000 + i), (i % 5) == 4, 1'b1, acc);

    $display("[TB] random backpressure");
    for (int i = 0; i < 200; i++)
      applyStimulus(0, ($urandom_range(3, 0) != 0), 16'($urandom), 1'($urandom), 1'($urandom), acc);
    drainAll(0);

    $display("[TB] packet mode, 5-beat packet");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1'b1, 16'(16'h2000 + i), i == 4, 1'b1, acc);
    chk("pk_valid_after_tlast", 32'(m_if1.tvalid), 32'd1);
    chk("pk_count_after_tlast", 32'(pkt1), 32'd1);
    drainAll(1);

    $display("[TB] packet mode, oversize packet");
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      applyStimulus(1, 1'b1, 16'(16'hA000 + n), n == 19, 1'b1, acc);
      if (acc) n++;
    end
    drainAll(1);

    $display("[TB] packet mode, random traffic");
    for (int i = 0; i < 120; i++)
      applyStimulus(1, 1'($urandom), 16'($urandom), ($urandom_range(3, 0) == 0), 1'($urandom), acc);
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) applyStimulus(1, 1'b1, 16'hBEEF, 1'b1, 1'b1, acc);
    drainAll(1);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 7; i++) applyStimulus(0, 1'b1, 16'(16'h3000 + i), 1'b0, 1'b0, acc);
    chk("ct_pre_reset_fill", 32'(fill0), 32'd7);
    pulseReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 16'(16'h4000 + i), i == 2, 1'b0, acc);
    drainAll(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
